// File: rtl/csr_trap_sequencer_if.sv
// Bundle of signals between the decode/execute stage, the CSR register file
// and the trap sequencer. The sequencer uses the master view; the core and
// CSR file side (or a testbench standing in for them) uses the slave view.
interface csr_trap_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] csr_rdata;
  logic        csr_w;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        busy;

  modport master (
    input  instr_valid, instr, pc, rs1_data, csr_rdata,
    output csr_w, csr_addr, csr_wdata, rd_we, rd_addr, rd_data,
           pc_redirect, pc_target, busy
  );

  modport slave (
    output instr_valid, instr, pc, rs1_data, csr_rdata,
    input  csr_w, csr_addr, csr_wdata, rd_we, rd_addr, rd_data,
           pc_redirect, pc_target, busy
  );
endinterface

// File: rtl/csr_trap_sequencer.sv
// CSR trap sequencer: decodes SYSTEM instructions, performs csrrw/csrrwi in a
// single cycle, and walks the trap-entry / trap-return CSR updates one write
// per cycle through the single CSR register-file port.
module csr_trap_sequencer #(
  parameter logic [11:0] ADDR_MSTATUS  = 12'h000,
  parameter logic [11:0] ADDR_MTVEC    = 12'h005,
  parameter logic [11:0] ADDR_MEPC     = 12'h041,
  parameter logic [11:0] ADDR_MCAUSE   = 12'h042,
  parameter logic [11:0] ADDR_MIP      = 12'h044,
  parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
  parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
  parameter logic [31:0] CAUSE_ECALL   = 32'd11
) (
  input logic                   clk,
  input logic                   rst_n,
  csr_trap_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_EPC,
    S_T_CAUSE,
    S_T_STATUS,
    S_T_VEC,
    S_M_STATUS,
    S_M_EPC
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;

  logic [2:0]  funct3;
  logic [11:0] csr_sel;
  logic [4:0]  rd_sel;
  logic [31:0] zimm;
  logic        addr_known;
  logic        is_csr_op;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic [31:0] trap_cause;
  logic        unused_opcode;

  logic        csr_w;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        busy;

  // The opcode field is qualified upstream by instr_valid.
  assign unused_opcode = ^bus.instr[6:0];

  assign funct3  = bus.instr[14:12];
  assign csr_sel = bus.instr[31:20];
  assign rd_sel  = bus.instr[11:7];
  assign zimm    = {27'd0, bus.instr[19:15]};

  // Only the five implemented CSRs may be targeted; anything else traps.
  assign addr_known = (csr_sel == ADDR_MSTATUS) || (csr_sel == ADDR_MTVEC) ||
                      (csr_sel == ADDR_MEPC)    || (csr_sel == ADDR_MCAUSE) ||
                      (csr_sel == ADDR_MIP);
  assign is_csr_op  = ((funct3 == 3'b001) || (funct3 == 3'b101)) && addr_known;
  assign is_ecall   = (funct3 == 3'b000) && (csr_sel == 12'h000);
  assign is_ebreak  = (funct3 == 3'b000) && (csr_sel == 12'h001);
  assign is_mret    = (funct3 == 3'b000) && (csr_sel == 12'h302);
  assign trap_cause = is_ecall  ? CAUSE_ECALL  :
                      is_ebreak ? CAUSE_EBREAK : CAUSE_ILLEGAL;

  // State register plus the pc and cause captured when a trap is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and port outputs; each sequencing state owns the CSR port.
  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    csr_w       = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    rd_we       = 1'b0;
    rd_addr     = '0;
    rd_data     = '0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    busy        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          if (is_csr_op) begin
            csr_w     = 1'b1;
            csr_addr  = csr_sel;
            csr_wdata = funct3[2] ? zimm : bus.rs1_data;
            rd_addr   = rd_sel;
            rd_data   = bus.csr_rdata;
            rd_we     = (rd_sel != 5'd0);
          end else if (is_mret) begin
            busy    = 1'b1;
            state_d = S_M_STATUS;
          end else begin
            busy    = 1'b1;
            epc_d   = bus.pc;
            cause_d = trap_cause;
            state_d = S_T_EPC;
          end
        end
      end
      S_T_EPC: begin
        busy      = 1'b1;
        csr_w     = 1'b1;
        csr_addr  = ADDR_MEPC;
        csr_wdata = epc_q;
        state_d   = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        busy      = 1'b1;
        csr_w     = 1'b1;
        csr_addr  = ADDR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = S_T_STATUS;
      end
      S_T_STATUS: begin
        busy         = 1'b1;
        csr_w        = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_wdata    = bus.csr_rdata;
        csr_wdata[7] = bus.csr_rdata[3];
        csr_wdata[3] = 1'b0;
        state_d      = S_T_VEC;
      end
      S_T_VEC: begin
        busy        = 1'b1;
        csr_addr    = ADDR_MTVEC;
        pc_redirect = 1'b1;
        pc_target   = {bus.csr_rdata[31:2], 2'b00};
        state_d     = S_IDLE;
      end
      S_M_STATUS: begin
        busy         = 1'b1;
        csr_w        = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_wdata    = bus.csr_rdata;
        csr_wdata[3] = bus.csr_rdata[7];
        csr_wdata[7] = 1'b1;
        state_d      = S_M_EPC;
      end
      S_M_EPC: begin
        busy        = 1'b1;
        csr_addr    = ADDR_MEPC;
        pc_redirect = 1'b1;
        pc_target   = {bus.csr_rdata[31:2], 2'b00};
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.csr_w       = csr_w;
  assign bus.csr_addr    = csr_addr;
  assign bus.csr_wdata   = csr_wdata;
  assign bus.rd_we       = rd_we;
  assign bus.rd_addr     = rd_addr;
  assign bus.rd_data     = rd_data;
  assign bus.pc_redirect = pc_redirect;
  assign bus.pc_target   = pc_target;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Testbench for csr_trap_sequencer: models the CSR register file, drives
// directed vectors and random SYSTEM instructions, and compares every cycle
// against a transaction-level reference of the instruction's effects.
module tb_csr_trap_sequencer;

  localparam logic [11:0] A_MSTATUS = 12'h000;
  localparam logic [11:0] A_MTVEC   = 12'h005;
  localparam logic [11:0] A_MEPC    = 12'h041;
  localparam logic [11:0] A_MCAUSE  = 12'h042;
  localparam logic [11:0] A_MIP     = 12'h044;
  localparam logic [31:0] ECALL     = 32'h0000_0073;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [31:0] MRET      = 32'h3020_0073;

  typedef struct {
    logic        busy;
    logic        csr_w;
    logic        chk_addr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rd_we;
    logic        chk_rd;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        redirect;
    logic [31:0] target;
  } cyc_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_rd_we;
    logic [4:0]  e_rd;
    logic [31:0] e_rd_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_trap_sequencer_if bus();

  csr_trap_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // CSR register file stand-in: combinational read, write at the clock edge.
  logic [31:0] m_status = '0;
  logic [31:0] m_tvec   = '0;
  logic [31:0] m_epc    = '0;
  logic [31:0] m_cause  = '0;
  logic [31:0] m_ip     = '0;
  int          unmapped_writes = 0;

  always_comb begin
    case (bus.csr_addr)
      A_MSTATUS: bus.csr_rdata = m_status;
      A_MTVEC:   bus.csr_rdata = m_tvec;
      A_MEPC:    bus.csr_rdata = m_epc;
      A_MCAUSE:  bus.csr_rdata = m_cause;
      A_MIP:     bus.csr_rdata = m_ip;
      default:   bus.csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.csr_w) begin
      case (bus.csr_addr)
        A_MSTATUS: m_status <= bus.csr_wdata;
        A_MTVEC:   m_tvec   <= bus.csr_wdata;
        A_MEPC:    m_epc    <= bus.csr_wdata;
        A_MCAUSE:  m_cause  <= bus.csr_wdata;
        A_MIP:     m_ip     <= bus.csr_wdata;
        default:   unmapped_writes <= unmapped_writes + 1;
      endcase
    end
  end

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_csr [5];
  logic [11:0] addrs [5];
  cyc_t        exp_q [$];
  vec_t        tbl [7];

  function automatic int csr_index(input logic [11:0] a);
    case (a)
      A_MSTATUS: return 0;
      A_MTVEC:   return 1;
      A_MEPC:    return 2;
      A_MCAUSE:  return 3;
      A_MIP:     return 4;
      default:   return -1;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc_v,
                                input logic [31:0] rs1_v);
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.pc          = pc_v;
    bus.rs1_data    = rs1_v;
  endtask

  // Reference: the architectural effect of one instruction, laid out as the
  // per-cycle port activity it must produce, and applied to ref_csr.
  task automatic build_expect(input logic [31:0] ins, input logic [31:0] pc_v, input logic [31:0] rs1_v);
    logic [2:0]  f3;
    logic [11:0] c;
    int          ci;
    logic [31:0] ms;
    logic [31:0] new_ms;
    logic [31:0] cause;
    cyc_t        cy;
    f3 = ins[14:12];
    c  = ins[31:20];
    ci = csr_index(c);
    exp_q.delete();
    if ((f3 == 3'b001 || f3 == 3'b101) && ci >= 0) begin
      cy = '{default: '0};
      cy.csr_w   = 1'b1;
      cy.addr    = c;
      cy.wdata   = (f3 == 3'b101) ? {27'd0, ins[19:15]} : rs1_v;
      cy.rd_we   = (ins[11:7] != 5'd0);
      cy.chk_rd  = 1'b1;
      cy.rd_addr = ins[11:7];
      cy.rd_data = ref_csr[ci];
      exp_q.push_back(cy);
      ref_csr[ci] = cy.wdata;
    end else if (f3 == 3'b000 && c == 12'h302) begin
      ms = ref_csr[0];
      new_ms = ms;
      new_ms[3] = ms[7];
      new_ms[7] = 1'b1;
      cy = '{default: '0}; cy.busy = 1'b1;
      exp_q.push_back(cy);
      cy.csr_w = 1'b1; cy.addr = A_MSTATUS; cy.wdata = new_ms;
      exp_q.push_back(cy);
      cy = '{default: '0}; cy.busy = 1'b1; cy.chk_addr = 1'b1; cy.addr = A_MEPC;
      cy.redirect = 1'b1; cy.target = ref_csr[2] & 32'hFFFF_FFFC;
      exp_q.push_back(cy);
      ref_csr[0] = new_ms;
    end else begin
      if (f3 == 3'b000 && c == 12'h000)      cause = 32'd11;
      else if (f3 == 3'b000 && c == 12'h001) cause = 32'd3;
      else                                   cause = 32'd2;
      ms = ref_csr[0];
      new_ms = ms;
      new_ms[7] = ms[3];
      new_ms[3] = 1'b0;
      cy = '{default: '0}; cy.busy = 1'b1;
      exp_q.push_back(cy);
      cy.csr_w = 1'b1; cy.addr = A_MEPC; cy.wdata = pc_v;
      exp_q.push_back(cy);
      cy.addr = A_MCAUSE; cy.wdata = cause;
      exp_q.push_back(cy);
      cy.addr = A_MSTATUS; cy.wdata = new_ms;
      exp_q.push_back(cy);
      cy = '{default: '0}; cy.busy = 1'b1; cy.chk_addr = 1'b1; cy.addr = A_MTVEC;
      cy.redirect = 1'b1; cy.target = ref_csr[1] & 32'hFFFF_FFFC;
      exp_q.push_back(cy);
      ref_csr[2] = pc_v;
      ref_csr[3] = cause;
      ref_csr[0] = new_ms;
    end
  endtask

  task automatic check_cycle(input cyc_t e, input string tag);
    check_output({tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
    check_output({tag, ".csr_w"}, 32'(bus.csr_w), 32'(e.csr_w));
    check_output({tag, ".rd_we"}, 32'(bus.rd_we), 32'(e.rd_we));
    check_output({tag, ".redirect"}, 32'(bus.pc_redirect), 32'(e.redirect));
    if (e.csr_w || e.chk_addr) check_output({tag, ".csr_addr"}, 32'(bus.csr_addr), 32'(e.addr));
    if (e.csr_w)    check_output({tag, ".wdata"}, bus.csr_wdata, e.wdata);
    if (e.chk_rd) begin
      check_output({tag, ".rd_addr"}, 32'(bus.rd_addr), 32'(e.rd_addr));
      check_output({tag, ".rd_data"}, bus.rd_data, e.rd_data);
    end
    if (e.redirect) check_output({tag, ".target"}, bus.pc_target, e.target);
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    check_output({tag, ".idle_csr_w"}, 32'(bus.csr_w), 32'd0);
    check_output({tag, ".idle_addr"}, 32'(bus.csr_addr), 32'd0);
    check_output({tag, ".idle_rd_we"}, 32'(bus.rd_we), 32'd0);
    check_output({tag, ".idle_redirect"}, 32'(bus.pc_redirect), 32'd0);
    check_output({tag, ".idle_target"}, bus.pc_target, 32'd0);
  endtask

  task automatic check_csr_file(input string tag);
    check_output({tag, ".mstatus"}, m_status, ref_csr[0]);
    check_output({tag, ".mtvec"}, m_tvec, ref_csr[1]);
    check_output({tag, ".mepc"}, m_epc, ref_csr[2]);
    check_output({tag, ".mcause"}, m_cause, ref_csr[3]);
    check_output({tag, ".mip"}, m_ip, ref_csr[4]);
    check_output({tag, ".unmapped"}, 32'(unmapped_writes), 32'd0);
  endtask

  // Runs one instruction from IDLE; entered and left just after a rising edge.
  // While busy, other instructions are offered and must be ignored.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] pc_v, input logic [31:0] rs1_v,
                           input bit hold, input string tag);
    logic [31:0] junk;
    int          n;
    build_expect(ins, pc_v, rs1_v);
    n = exp_q.size();
    apply_stimulus(1'b1, ins, pc_v, rs1_v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle(exp_q[i], $sformatf("%s.c%0d", tag, i));
      @(posedge clk);
      #1;
      if (i + 1 < n) begin
        if (hold) begin
          apply_stimulus(1'b1, {A_MTVEC, 5'd1, 3'b001, 5'd6, 7'h73}, 32'h0000_0FF0, 32'hDEAD_BEE0);
        end else begin
          junk = $urandom;
          junk[6:0] = 7'h73;
          apply_stimulus(1'($urandom_range(0, 1)), junk, $urandom, $urandom);
        end
      end else begin
        apply_stimulus(1'b0, 32'd0, 32'd0, 32'd0);
      end
    end
    @(negedge clk);
    check_idle(tag);
    @(posedge clk);
    #1;
    check_csr_file(tag);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] prev_cause;
    int          k;

    addrs[0] = A_MSTATUS; addrs[1] = A_MTVEC; addrs[2] = A_MEPC;
    addrs[3] = A_MCAUSE;  addrs[4] = A_MIP;
    for (int i = 0; i < 5; i++) ref_csr[i] = '0;

    // csr, rs1, expected addr/wdata/rd_we/rd/rd_data, in order from reset
    tbl[0] = '{{12'h005, 5'd1, 3'b001, 5'd5, 7'h73}, 32'h0000_0100, 12'h005, 32'h0000_0100, 1'b1, 5'd5, 32'h0};
    tbl[1] = '{{12'h000, 5'd8, 3'b101, 5'd0, 7'h73}, 32'hDEAD_0000, 12'h000, 32'h0000_0008, 1'b0, 5'd0, 32'h0};
    tbl[2] = '{{12'h005, 5'd2, 3'b001, 5'd7, 7'h73}, 32'h0000_0200, 12'h005, 32'h0000_0200, 1'b1, 5'd7, 32'h100};
    tbl[3] = '{{12'h005, 5'd2, 3'b001, 5'd3, 7'h73}, 32'h0000_0100, 12'h005, 32'h0000_0100, 1'b1, 5'd3, 32'h200};
    tbl[4] = '{{12'h044, 5'd31, 3'b101, 5'd9, 7'h73}, 32'h1234_5678, 12'h044, 32'h0000_001F, 1'b1, 5'd9, 32'h0};
    tbl[5] = '{{12'h044, 5'd4, 3'b001, 5'd0, 7'h73}, 32'h0000_0000, 12'h044, 32'h0000_0000, 1'b0, 5'd0, 32'h1F};
    tbl[6] = '{{12'h000, 5'd8, 3'b101, 5'd2, 7'h73}, 32'h0, 12'h000, 32'h0000_0008, 1'b1, 5'd2, 32'h8};

    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      build_expect(tbl[i].instr, 32'd0, tbl[i].rs1);
      apply_stimulus(1'b1, tbl[i].instr, 32'd0, tbl[i].rs1);
      @(negedge clk);
      check_output($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'd0);
      check_output($sformatf("vec%0d.redirect", i), 32'(bus.pc_redirect), 32'd0);
      check_output($sformatf("vec%0d.csr_w", i), 32'(bus.csr_w), 32'd1);
      check_output($sformatf("vec%0d.csr_addr", i), 32'(bus.csr_addr), 32'(tbl[i].e_addr));
      check_output($sformatf("vec%0d.wdata", i), bus.csr_wdata, tbl[i].e_wdata);
      check_output($sformatf("vec%0d.rd_we", i), 32'(bus.rd_we), 32'(tbl[i].e_rd_we));
      check_output($sformatf("vec%0d.rd_addr", i), 32'(bus.rd_addr), 32'(tbl[i].e_rd));
      check_output($sformatf("vec%0d.rd_data", i), bus.rd_data, tbl[i].e_rd_data);
      @(posedge clk);
      #1;
      apply_stimulus(1'b0, 32'd0, 32'd0, 32'd0);
    end
    check_csr_file("table");
    check_output("table.mtvec_abs", m_tvec, 32'h0000_0100);

    run_instr(ECALL, 32'h0000_0040, 32'h0, 1'b1, "ecall");
    check_output("ecall.mepc_abs", m_epc, 32'h40);
    check_output("ecall.mcause_abs", m_cause, 32'd11);
    check_output("ecall.mstatus_abs", m_status, 32'h80);
    check_output("ecall.mtvec_held", m_tvec, 32'h100);

    run_instr(MRET, 32'h0000_0100, 32'h0, 1'b0, "mret");
    check_output("mret.mstatus_abs", m_status, 32'h88);

    run_instr(EBREAK, 32'h0000_0040, 32'h0, 1'b0, "ebreak");
    check_output("ebreak.mcause_abs", m_cause, 32'd3);
    check_output("ebreak.mstatus_abs", m_status, 32'h80);

    run_instr({12'h005, 5'd1, 3'b010, 5'd4, 7'h73}, 32'h0000_0080, 32'hFFFF_FFFF, 1'b0, "csrrs");
    check_output("csrrs.mcause_abs", m_cause, 32'd2);
    check_output("csrrs.mepc_abs", m_epc, 32'h80);
    check_output("csrrs.mtvec_abs", m_tvec, 32'h100);

    run_instr({12'h300, 5'd1, 3'b001, 5'd4, 7'h73}, 32'h0000_0080, 32'hFFFF_FFFF, 1'b0, "badaddr");
    check_output("badaddr.mcause_abs", m_cause, 32'd2);
    check_output("badaddr.mepc_abs", m_epc, 32'h80);

    // Reset while the trap is in its mcause step.
    prev_cause = ref_csr[3];
    apply_stimulus(1'b1, ECALL, 32'h0000_00C0, 32'h0);
    @(negedge clk);
    check_output("rst.c0_busy", 32'(bus.busy), 32'd1);
    check_output("rst.c0_csr_w", 32'(bus.csr_w), 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    check_output("rst.epc_addr", 32'(bus.csr_addr), 32'(A_MEPC));
    check_output("rst.epc_wdata", bus.csr_wdata, 32'hC0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("rst.cause_addr", 32'(bus.csr_addr), 32'(A_MCAUSE));
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("rst.async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_output("rst.no_redirect", 32'(bus.pc_redirect), 32'd0);
      check_output("rst.no_write", 32'(bus.csr_w), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ref_csr[2] = 32'hC0;
    check_output("rst.mepc_kept", m_epc, 32'hC0);
    check_output("rst.mcause_same", m_cause, prev_cause);
    check_csr_file("rst");

    run_instr({12'h044, 5'd7, 3'b101, 5'd1, 7'h73}, 32'h0, 32'h0, 1'b0, "post_rst");

    for (int n = 0; n < 250; n++) begin
      w = $urandom;
      w[6:0] = 7'h73;
      k = $urandom_range(0, 9);
      case (k)
        0, 1: begin w[31:20] = addrs[$urandom_range(0, 4)]; w[14:12] = 3'b001; end
        2, 3: begin w[31:20] = addrs[$urandom_range(0, 4)]; w[14:12] = 3'b101; end
        4:    w[14:12] = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101;
        5:    begin w[31:20] = 12'h000; w[14:12] = 3'b000; end
        6:    begin w[31:20] = 12'h001; w[14:12] = 3'b000; end
        7:    begin w[31:20] = 12'h302; w[14:12] = 3'b000; end
        8:    w[14:12] = 3'($urandom_range(0, 7));
        default: w[14:12] = 3'b000;
      endcase
      run_instr(w, $urandom, $urandom, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
